// File: rtl/apu_pkg.sv
// Shared types and constants for the APU event scheduler.
package apu_pkg;

  localparam int unsigned TIMEOUT_CYC_DEF = 1024;
  localparam int unsigned ERR_W           = 2;
  localparam int unsigned ERR_WR_SPUR     = 0;
  localparam int unsigned ERR_RD_TMO      = 1;
  localparam int unsigned BUF_N           = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } rd_state_e;

  // One-hot select of a two-entry buffer pair
  function automatic logic [BUF_N-1:0] idx_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/apu_idx_fifo.sv
// Two-entry FIFO of 1-bit downstream indices awaiting APU write completion.
// Exposes next-state head/count so the owner can register views of the queue.
module apu_idx_fifo
  import apu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       push_idx,
  input  logic       pop,
  input  logic       drop_tail,
  output logic       head,
  output logic [1:0] count,
  output logic [1:0] queued_c,
  output logic       head_nxt_c,
  output logic [1:0] count_nxt_c
);

  logic q0;
  logic q1;
  logic q0_nxt;
  logic q1_nxt;

  // Pop first, then drop the newest entry, then append
  always_comb begin
    q0_nxt      = q0;
    q1_nxt      = q1;
    count_nxt_c = count;
    if (pop && (count != 2'd0)) begin
      q0_nxt      = q1;
      count_nxt_c = count - 2'd1;
    end
    if (drop_tail && (count_nxt_c != 2'd0)) begin
      count_nxt_c = count_nxt_c - 2'd1;
    end
    if (push && (count_nxt_c != 2'd2)) begin
      if (count_nxt_c == 2'd0) begin
        q0_nxt = push_idx;
      end else begin
        q1_nxt = push_idx;
      end
      count_nxt_c = count_nxt_c + 2'd1;
    end
  end

  assign head_nxt_c = q0_nxt;

  // Mask of downstream buffers currently owned by the queue
  always_comb begin
    queued_c = '0;
    if (count != 2'd0) begin
      queued_c[q0] = 1'b1;
    end
    if (count == 2'd2) begin
      queued_c[q1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q0    <= 1'b0;
      q1    <= 1'b0;
      count <= 2'd0;
    end else begin
      q0    <= q0_nxt;
      q1    <= q1_nxt;
      count <= count_nxt_c;
    end
  end

  assign head = q0;

endmodule

// File: rtl/apu_evt_sched.sv
// Schedules events from two upstream buffers through the APU into two downstream buffers.
// Optional read timeout enabled by defining APU_SCHED_TIMEOUT_EN.
module apu_evt_sched
  import apu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       up_full,
  output logic             up_sel,
  output logic [1:0]       up_release,
  input  logic [1:0]       dn_empty,
  output logic             dn_sel,
  output logic [1:0]       dn_commit,
  output logic             apu_ready,
  input  logic             apu_rd_done,
  input  logic             apu_wr_done,
  output logic [CNT_W-1:0] evt_cnt,
  output logic [ERR_W-1:0] err
);

  rd_state_e state;
  rd_state_e state_nxt;

  logic       rr_ptr;
  logic       last_dn;
  logic       q_head;
  logic [1:0] q_count;
  logic [1:0] q_queued;
  logic       q_head_nxt;
  logic [1:0] q_count_nxt;

  logic [1:0] dn_free;
  logic       can_grant;
  logic       grant;
  logic       up_pick;
  logic       dn_pick;
  logic       pop_ok;
  logic       tmo_hit;

  logic             apu_ready_d;
  logic [1:0]       up_release_d;
  logic [1:0]       dn_commit_d;
  logic [CNT_W-1:0] evt_cnt_d;
  logic [ERR_W-1:0] err_d;
  logic             up_sel_d;
  logic             dn_sel_d;
  logic             rr_d;
  logic             last_dn_d;

  // Grant arbitration: round-robin upstream, lowest free downstream not already queued
  assign dn_free   = dn_empty & ~q_queued;
  assign can_grant = (up_full != 2'b00) && (dn_free != 2'b00) && (q_count != 2'd2);
  assign grant     = (state == ST_IDLE) && can_grant;
  assign up_pick   = (up_full == 2'b11) ? ~rr_ptr : up_full[1];
  assign dn_pick   = ~dn_free[0];
  assign pop_ok    = apu_wr_done && (q_count != 2'd0);

`ifdef APU_SCHED_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Counts cycles spent in RUN for the current event
  always_ff @(posedge clk) begin
    if (reset || (state != ST_RUN)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit = (state == ST_RUN) && !apu_rd_done
                   && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign tmo_hit            = 1'b0;
`endif

  apu_idx_fifo u_pend (
    .clk         (clk),
    .reset       (reset),
    .push        (grant),
    .push_idx    (dn_pick),
    .pop         (apu_wr_done),
    .drop_tail   (tmo_hit),
    .head        (q_head),
    .count       (q_count),
    .queued_c    (q_queued),
    .head_nxt_c  (q_head_nxt),
    .count_nxt_c (q_count_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (can_grant) state_nxt = ST_RUN;
      ST_RUN:  if (apu_rd_done || tmo_hit) state_nxt = ST_GAP;
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of all registered outputs
  always_comb begin
    apu_ready_d  = (state_nxt == ST_RUN);
    up_release_d = 2'b00;
    dn_commit_d  = 2'b00;
    evt_cnt_d    = evt_cnt;
    err_d        = err;
    up_sel_d     = up_sel;
    rr_d         = rr_ptr;
    last_dn_d    = last_dn;

    if (state_nxt == ST_GAP) begin
      up_release_d = idx_onehot(up_sel);
    end
    if (pop_ok) begin
      dn_commit_d = idx_onehot(q_head);
      evt_cnt_d   = evt_cnt + CNT_W'(1);
    end
    if (apu_wr_done && (q_count == 2'd0)) begin
      err_d[ERR_WR_SPUR] = 1'b1;
    end
    if (tmo_hit) begin
      err_d[ERR_RD_TMO] = 1'b1;
    end
    if (grant) begin
      up_sel_d  = up_pick;
      rr_d      = up_pick;
      last_dn_d = dn_pick;
    end
    dn_sel_d = (q_count_nxt != 2'd0) ? q_head_nxt : last_dn_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      apu_ready  <= 1'b0;
      up_release <= 2'b00;
      dn_commit  <= 2'b00;
      evt_cnt    <= '0;
      err        <= '0;
      up_sel     <= 1'b0;
      dn_sel     <= 1'b0;
      rr_ptr     <= 1'b1;
      last_dn    <= 1'b0;
    end else begin
      apu_ready  <= apu_ready_d;
      up_release <= up_release_d;
      dn_commit  <= dn_commit_d;
      evt_cnt    <= evt_cnt_d;
      err        <= err_d;
      up_sel     <= up_sel_d;
      dn_sel     <= dn_sel_d;
      rr_ptr     <= rr_d;
      last_dn    <= last_dn_d;
    end
  end

endmodule

// File: doc/apu_evt_sched.md
APU_EVT_SCHED -- requirements
Module: apu_evt_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1024: cycles allowed from grant to apu_rd_done (used only with APU_SCHED_TIMEOUT_EN).
REQ-002 SHALL have parameter CNT_W, default 16: width of the completed-event counter.
REQ-003 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port up_full, input, 2: upstream buffer n holds one complete event.
REQ-006 SHALL have port up_sel, output, 1: upstream buffer muxed onto the APU read ports.
REQ-007 SHALL have port up_release, output, 2: one-cycle pulse freeing upstream buffer n.
REQ-008 SHALL have port dn_empty, input, 2: downstream buffer n is free to receive an event.
REQ-009 SHALL have port dn_sel, output, 1: downstream buffer muxed onto the APU write port.
REQ-010 SHALL have port dn_commit, output, 2: one-cycle pulse marking downstream buffer n filled.
REQ-011 SHALL have port apu_ready, output, 1: drives APU rd_EvTID_ready.
REQ-012 SHALL have port apu_rd_done, input, 1: APU rd_EvTID_DONE pulse.
REQ-013 SHALL have port apu_wr_done, input, 1: APU wr_EvTID_DONE pulse.
REQ-014 SHALL have port evt_cnt, output, CNT_W: count of committed events, wraps modulo 2^CNT_W.
REQ-015 SHALL have port err, output, 2: sticky; bit0 = spurious wr_done, bit1 = read timeout.

Function
REQ-016 SHALL implement read FSM states IDLE, RUN, GAP.
REQ-017 IDLE->RUN when an eligible upstream buffer exists, a downstream buffer is neither in flight nor non-empty, and pending count < 2.
REQ-018 On IDLE->RUN, SHALL latch up_sel and dn_sel and push dn_sel into the pending queue, in the same edge.
REQ-019 Upstream choice SHALL be round-robin: the buffer not granted last wins when both are full.
REQ-020 Downstream choice SHALL be the lowest-index free buffer.
REQ-021 apu_ready SHALL be 1 exactly while state is RUN.
REQ-022 RUN->GAP on apu_rd_done; GAP SHALL last exactly one cycle with apu_ready=0 and up_release[up_sel]=1.
REQ-023 GAP->IDLE unconditionally; the earliest next grant is the cycle after GAP, so apu_ready is low for at least 2 cycles between events.
REQ-024 apu_rd_done outside RUN SHALL be ignored.
REQ-025 Pending queue SHALL be a 2-entry FIFO of downstream indices, in grant order.
REQ-026 On apu_wr_done with the queue non-empty: pop head, pulse dn_commit[head] for one cycle, increment evt_cnt.
REQ-027 On apu_wr_done with the queue empty: set err[0]; no commit, no count.
REQ-028 A simultaneous push and pop SHALL both take effect; count unchanged.
REQ-029 dn_sel SHALL track the queue head while the queue is non-empty, else the last granted index.
REQ-030 A queued downstream index SHALL be excluded from selection even if dn_empty reports it free.

Reset
REQ-031 On reset, state=IDLE, queue flushed, up_sel=0, dn_sel=0, round-robin pointer=1 (buffer 0 wins first), evt_cnt=0, err=0.
REQ-032 On reset, up_release, dn_commit and apu_ready SHALL be 0.
REQ-033 Reset mid-event SHALL abandon the event with no release or commit pulses.

Configuration
REQ-034 Macro APU_SCHED_TIMEOUT_EN defined: a timer counts RUN cycles.
REQ-035 With APU_SCHED_TIMEOUT_EN, reaching TIMEOUT_CYC without apu_rd_done SHALL set err[1] and enter GAP (normal release), and SHALL drop the queue tail entry pushed for this event.
REQ-036 Without APU_SCHED_TIMEOUT_EN: no timer; RUN waits indefinitely; err[1] tied to 0.

Structure
REQ-037 Shared package apu_pkg SHALL hold the read FSM state enum, the err bit index constants and the TIMEOUT_CYC default.
REQ-038 Sub-module apu_idx_fifo (2-entry, 1-bit data, push/pop/count) SHALL implement the pending queue.

Verification
REQ-039 Reset, then up_full=01, dn_empty=11 -> apu_ready=1 next cycle, up_sel=0, dn_sel=0; rd_done -> up_release=01 one cycle later.
REQ-040 up_full=11 held across two events -> grants alternate up_sel 0,1; apu_ready low exactly 2 cycles between grants.
REQ-041 Two events granted before any wr_done -> third not granted; two wr_done -> dn_commit 01 then 10, evt_cnt=2.
REQ-042 apu_wr_done with queue empty -> err=01, evt_cnt unchanged, no dn_commit.
REQ-043 With APU_SCHED_TIMEOUT_EN and TIMEOUT_CYC=8, no rd_done -> err[1]=1 after 8 RUN cycles, up_release pulse, queue count restored.
REQ-044 Reset asserted in RUN -> apu_ready=0 next cycle, no release/commit pulses, evt_cnt=0.
